// File: rtl/serial_subtractor_if.sv
// Start/ready/done handshake and result bus between a controller and the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         neg;
  logic         zero;

  modport master (
    output start, a, b,
    input  ready, done, diff, borrow, ovf, neg, zero
  );

  modport slave (
    input  start, a, b,
    output ready, done, diff, borrow, ovf, neg, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first: one full-subtractor cell plus a borrow flop, N cycles per operation.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus
);
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [N-1:0]    r_a_sh, r_b_sh, r_res;
  logic            r_bff;
  logic [CW-1:0]   r_cnt;
  logic            r_a_msb, r_b_msb;
  logic [N-1:0]    r_diff;
  logic            r_borrow, r_ovf, r_neg, r_zero;

  logic            w_ai, w_bi, w_d, w_bout, w_last;
  logic [N-1:0]    w_res_nxt;

  // Full-subtractor cell
  always_comb begin
    w_ai      = r_a_sh[0];
    w_bi      = r_b_sh[0];
    w_d       = w_ai ^ w_bi ^ r_bff;
    w_bout    = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bff);
    w_res_nxt = {w_d, r_res[N-1:1]};
    w_last    = (r_cnt == CW'(N-1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) w_next = S_RUN;
      end
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers load on the final RUN edge so they are valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res    <= '0;
      r_bff    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_a_sh  <= bus.a;
          r_b_sh  <= bus.b;
          r_a_msb <= bus.a[N-1];
          r_b_msb <= bus.b[N-1];
          r_bff   <= 1'b0;
          r_cnt   <= '0;
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_res  <= w_res_nxt;
          r_bff  <= w_bout;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_neg    <= w_d;
            r_zero   <= (w_res_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.diff   = r_diff;
    bus.borrow = r_borrow;
    bus.ovf    = r_ovf;
    bus.neg    = r_neg;
    bus.zero   = r_zero;
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor against an integer-arithmetic reference model.
module tb_serial_subtractor;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.N(N)) bus ();
  serial_subtractor #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {zero, neg, ovf, borrow, diff} from plain signed/unsigned arithmetic
  function automatic logic [N+3:0] ref_sub(input int a, input int b);
    int d, sa, sb, sd;
    logic [N-1:0] dv;
    d  = a - b;
    dv = N'(d & ((1 << N) - 1));
    sa = (a >= (1 << (N-1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N-1))) ? b - (1 << N) : b;
    sd = sa - sb;
    return {dv == 0, d < 0 ? dv[N-1] : dv[N-1],
            (sd > (1 << (N-1)) - 1) || (sd < -(1 << (N-1))),
            a < b, dv};
  endfunction

  function automatic logic [N+3:0] outs();
    return {bus.zero, bus.neg, bus.ovf, bus.borrow, bus.diff};
  endfunction

  task automatic check_res(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N+3:0] e;
    e = ref_sub(int'(a), int'(b));
    chk($sformatf("diff %0d-%0d", a, b), 32'(bus.diff), 32'(e[N-1:0]));
    chk("borrow", 32'(bus.borrow), 32'(e[N]));
    chk("ovf",    32'(bus.ovf),    32'(e[N+1]));
    chk("neg",    32'(bus.neg),    32'(e[N+2]));
    chk("zero",   32'(bus.zero),   32'(e[N+3]));
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.ready && t < 50) begin @(negedge clk); t++; end
    chk("ready_wait", 32'(bus.ready), 32'd1);
  endtask

  // One operation; optionally pulses a stray start with other operands mid-RUN
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit glitch);
    logic [N+3:0] prev;
    bit early = 0, held_bad = 0;
    wait_ready();
    prev      = outs();
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (bus.done || bus.ready) early = 1;
      if (outs() != prev) held_bad = 1;
      if (glitch && k == 2) begin
        bus.start = 1'b1; bus.a = '1; bus.b = '0;
      end else bus.start = 1'b0;
    end
    chk("busy_no_done", 32'(early), 32'd0);
    chk("outputs_held", 32'(held_bad), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_latency", 32'(bus.done), 32'd1);
    chk("ready_in_done", 32'(bus.ready), 32'd0);
    check_res(a, b);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("ready_back", 32'(bus.ready), 32'd1);
  endtask

  logic [2*N-1:0] pairs [256];
  logic [N-1:0]   bb_a [3];
  logic [N-1:0]   bb_b [3];
  int             bb_cyc [3];

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    #12;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_outs",  32'(outs()),    32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(4'b1001, 4'b0011, 0);
    do_op(4'b0011, 4'b1001, 0);
    do_op(4'b0101, 4'b0101, 0);
    do_op(4'b1000, 4'b0001, 0);
    do_op(4'b1001, 4'b0011, 1);

    // Reset during the second RUN cycle
    begin
      bit saw_done = 0;
      wait_ready();
      bus.a = 4'b1111; bus.b = 4'b0001; bus.start = 1'b1;
      @(posedge clk); #1; bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("midrst_ready", 32'(bus.ready), 32'd1);
      chk("midrst_done",  32'(bus.done),  32'd0);
      chk("midrst_outs",  32'(outs()),    32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (bus.done) saw_done = 1;
      end
      chk("midrst_no_done", 32'(saw_done), 32'd0);
      do_op(4'b0000, 4'b0001, 0);
    end

    // start held high: back-to-back operations every N+2 cycles
    bb_a = '{4'd7, 4'd2, 4'd12};
    bb_b = '{4'd3, 4'd9, 4'd12};
    begin
      int idx = 0;
      wait_ready();
      bus.a = bb_a[0]; bus.b = bb_b[0]; bus.start = 1'b1;
      for (int t = 0; t < 40 && idx < 3; t++) begin
        @(negedge clk);
        if (bus.done) begin
          bb_cyc[idx] = cyc;
          check_res(bb_a[idx], bb_b[idx]);
          idx++;
          if (idx < 3) begin bus.a = bb_a[idx]; bus.b = bb_b[idx]; end
          else bus.start = 1'b0;
        end
      end
      bus.start = 1'b0;
      chk("b2b_count", 32'(idx), 32'd3);
      chk("b2b_period1", 32'(bb_cyc[1] - bb_cyc[0]), 32'(N + 2));
      chk("b2b_period2", 32'(bb_cyc[2] - bb_cyc[1]), 32'(N + 2));
    end

    // All operand pairs in shuffled order
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [2*N-1:0] tmp;
      j = int'($urandom_range(0, i));
      tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
    end
    for (int i = 0; i < 256; i++)
      do_op(pairs[i][2*N-1:N], pairs[i][N-1:0], bit'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
